// File: rtl/ring_osc_meas_ctrl.sv
// ring_osc_meas_ctrl: selects, configures, settles and edge-counts one of 12 ring oscillators over a gated window.
module ring_osc_meas_ctrl #(
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       osc_sel,
  input  logic [7:0]       cfg_a,
  input  logic             cfg_ntest,
  input  logic [3:0]       gate_log2,
  input  logic [11:0]      osc_y,
  output logic [11:0]      osc_en,
  output logic [7:0]       osc_a,
  output logic             osc_ntest,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ovf,
  output logic [CNT_W-1:0] count
);
  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;
  state_t state, state_nxt;
  logic [3:0] sel_q, g_q;
  logic [7:0] a_q;
  logic ntest_q, sync_q, sync_qq, ovf_acc, ovf_nxt, inc, sat, run, sel_ok;
  logic [19:0] tmr;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [15:0] y_pad;
  assign y_pad = {4'b0, osc_y};
  assign sel_ok = osc_sel < 4'd12;
  assign inc = (state == MEASURE) && sync_q && !sync_qq;
  assign sat = &cnt;
  assign cnt_nxt = (inc && !sat) ? cnt + 1'b1 : cnt;
  assign ovf_nxt = ovf_acc | (inc & sat);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? (sel_ok ? SETTLE : DONE) : IDLE;
      SETTLE:  state_nxt = (tmr == '0) ? MEASURE : SETTLE;
      MEASURE: state_nxt = (tmr == '0) ? DONE : MEASURE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    run = (state == SETTLE) || (state == MEASURE);
    osc_en = run ? 12'(12'd1 << sel_q) : '0;
    osc_a = run ? a_q : '0;
    osc_ntest = run & ntest_q;
    busy = state != IDLE;
    done = state == DONE;
  end
  // the synchronizer keeps running through SETTLE so it is primed when counting begins
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sel_q <= '0;
      g_q <= '0;
      a_q <= '0;
      ntest_q <= 1'b0;
      sync_q <= 1'b0;
      sync_qq <= 1'b0;
      tmr <= '0;
      cnt <= '0;
      ovf_acc <= 1'b0;
      err <= 1'b0;
      ovf <= 1'b0;
      count <= '0;
    end else begin
      sync_q <= y_pad[sel_q];
      sync_qq <= sync_q;
      if (state == IDLE && start) begin
        sel_q <= osc_sel;
        g_q <= gate_log2;
        a_q <= cfg_a;
        ntest_q <= cfg_ntest;
        tmr <= 20'(SETTLE_CYCLES - 1);
        err <= !sel_ok;
        ovf <= 1'b0;
        if (!sel_ok) count <= '0;
      end
      if (state == SETTLE) begin
        tmr <= (tmr == '0) ? (20'd1 << (5'(g_q) + 5'd4)) - 20'd1 : tmr - 20'd1;
        cnt <= '0;
        ovf_acc <= 1'b0;
      end
      if (state == MEASURE) begin
        tmr <= tmr - 20'd1;
        cnt <= cnt_nxt;
        ovf_acc <= ovf_nxt;
        if (tmr == '0) begin
          count <= cnt_nxt;
          ovf <= ovf_nxt;
        end
      end
    end
endmodule
